// File: rtl/fpu_cmd_sequencer.sv
// Command sequencer: hands one request at a time to a multi-cycle FPU and returns its result.
// Optional macro FPU_SEQ_CYCLE_COUNT_EN enables the rsp_cycles latency report (otherwise it reads 0).
module fpu_cmd_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    input  logic [1:0]  req_op,
    output logic [15:0] fpu_x,
    output logic [15:0] fpu_y,
    output logic [1:0]  fpu_op,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [15:0] fpu_result,
    input  logic [1:0]  fpu_ofuf,
    input  logic [2:0]  fpu_comp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [1:0]  rsp_ofuf,
    output logic [2:0]  rsp_comp,
    output logic        rsp_err,
    output logic [15:0] rsp_cycles
);

    typedef enum logic [2:0] {IDLE, START, WAIT_CLR, WAIT, RESP} state_t;

    state_t      state_q;
    logic        reqReady_q;
    logic [15:0] fpuX_q;
    logic [15:0] fpuY_q;
    logic [1:0]  fpuOp_q;
    logic        fpuStart_q;
    logic        rspValid_q;
    logic [15:0] rspResult_q;
    logic [1:0]  rspOfuf_q;
    logic [2:0]  rspComp_q;
    logic        rspErr_q;
    logic [15:0] waitCnt_q;
    logic [15:0] waitCnt_d;
    logic        timeoutHit;

    // waitCnt_d is the number of WAIT cycles including the current one
    assign waitCnt_d  = (waitCnt_q == 16'hFFFF) ? waitCnt_q : waitCnt_q + 16'd1;
    assign timeoutHit = (waitCnt_d >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            reqReady_q  <= 1'b1;
            fpuX_q      <= 16'd0;
            fpuY_q      <= 16'd0;
            fpuOp_q     <= 2'd0;
            fpuStart_q  <= 1'b0;
            rspValid_q  <= 1'b0;
            rspResult_q <= 16'd0;
            rspOfuf_q   <= 2'd0;
            rspComp_q   <= 3'd0;
            rspErr_q    <= 1'b0;
            waitCnt_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        fpuX_q     <= req_x;
                        fpuY_q     <= req_y;
                        fpuOp_q    <= req_op;
                        fpuStart_q <= 1'b1;
                        reqReady_q <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    fpuStart_q <= 1'b0;
                    state_q    <= WAIT_CLR;
                end
                // fpu_done may still be high from the previous operation here
                WAIT_CLR: begin
                    waitCnt_q <= 16'd0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (fpu_done) begin
                        rspResult_q <= fpu_result;
                        rspOfuf_q   <= fpu_ofuf;
                        rspComp_q   <= fpu_comp;
                        rspErr_q    <= 1'b0;
                        rspValid_q  <= 1'b1;
                        state_q     <= RESP;
                    end else if (timeoutHit) begin
                        rspResult_q <= 16'h7E00;
                        rspOfuf_q   <= 2'd0;
                        rspComp_q   <= 3'd0;
                        rspErr_q    <= 1'b1;
                        rspValid_q  <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FPU_SEQ_CYCLE_COUNT_EN
    logic [15:0] rspCycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rspCycles_q <= 16'd0;
        end else if (state_q == WAIT && (fpu_done || timeoutHit)) begin
            rspCycles_q <= fpu_done ? waitCnt_d : TIMEOUT_CYCLES;
        end
    end

    assign rsp_cycles = rspCycles_q;
`else
    assign rsp_cycles = 16'd0;
`endif

    assign req_ready  = reqReady_q;
    assign fpu_x      = fpuX_q;
    assign fpu_y      = fpuY_q;
    assign fpu_op     = fpuOp_q;
    assign fpu_start  = fpuStart_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_result = rspResult_q;
    assign rsp_ofuf   = rspOfuf_q;
    assign rsp_comp   = rspComp_q;
    assign rsp_err    = rspErr_q;

endmodule
